// File: rtl/q_conv_pkg.sv
// Shared definitions for the quotient digit-register and on-the-fly conversion stages:
// FSM state type, default datapath widths and the chunk-counter width helper.
package q_conv_pkg;

    localparam int UNROLLING_DEF = 64;
    localparam int CHUNK_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Width of a counter that indexes nchunk chunks; never narrower than one bit.
    function automatic int cnt_width(input int nchunk);
        if (nchunk > 1) begin
            return $clog2(nchunk);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/q_chunk_sub.sv
// One CHUNK-wide subtract-with-borrow slice: {b_out, diff} = a - b - b_in.
module q_chunk_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    output logic [W-1:0] diff,
    output logic         b_out
);

    // The extra MSB of the widened difference is the outgoing borrow.
    assign {b_out, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, b_in};

endmodule

// File: rtl/q_otf_convert.sv
// Converts a redundant (q_plus, q_minus) digit pair into a two's-complement quotient,
// one CHUNK per clock, LSB first. Optional q_zero output under Q_OTF_ZERO_DETECT_EN.
module q_otf_convert
    import q_conv_pkg::*;
#(
    parameter int UNROLLING = UNROLLING_DEF,
    parameter int CHUNK     = CHUNK_DEF
) (
    input  logic                 clk,
    input  logic                 asyn_reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UNROLLING-1:0] q_plus,
    input  logic [UNROLLING-1:0] q_minus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UNROLLING-1:0] q_conv,
    output logic                 q_sign,
    output logic                 busy
`ifdef Q_OTF_ZERO_DETECT_EN
    ,
    output logic                 q_zero
`endif
);

    localparam int NCHUNK = UNROLLING / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    if ((UNROLLING % CHUNK) != 0) begin : g_chunk_check
        $error("q_otf_convert: UNROLLING must be a multiple of CHUNK");
    end

    conv_state_e                  state_r;
    conv_state_e                  state_nxt_s;
    logic [CW-1:0]                cnt_r;
    logic                         borrow_r;
    logic [NCHUNK-1:0][CHUNK-1:0] plus_r;
    logic [NCHUNK-1:0][CHUNK-1:0] minus_r;
    logic [NCHUNK-1:0][CHUNK-1:0] result_r;
    logic                         q_sign_r;
    logic                         out_valid_r;
    logic [CHUNK-1:0]             diff_s;
    logic                         b_out_s;
    logic                         load_s;
    logic                         step_s;
    logic                         last_s;
    logic                         release_s;
    logic                         in_ready_s;

    // Single subtractor slice, steered to the current chunk by the counter.
    q_chunk_sub #(
        .W(CHUNK)
    ) u_sub (
        .a     (plus_r[cnt_r]),
        .b     (minus_r[cnt_r]),
        .b_in  (borrow_r),
        .diff  (diff_s),
        .b_out (b_out_s)
    );

    // Next-state and control decode for the IDLE/CONV/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        load_s      = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            DONE: begin
                // Downstream acceptance frees the slot in the same cycle (zero-bubble chaining).
                in_ready_s = out_ready;
                if (out_ready) begin
                    release_s = 1'b1;
                    if (in_valid) begin
                        load_s      = 1'b1;
                        state_nxt_s = CONV;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, per-chunk result write and borrow/counter update.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            plus_r   <= {UNROLLING{1'b0}};
            minus_r  <= {UNROLLING{1'b0}};
            result_r <= {UNROLLING{1'b0}};
            cnt_r    <= {CW{1'b0}};
            borrow_r <= 1'b0;
        end else if (load_s) begin
            plus_r   <= q_plus;
            minus_r  <= q_minus;
            cnt_r    <= {CW{1'b0}};
            borrow_r <= 1'b0;
        end else if (step_s) begin
            result_r[cnt_r] <= diff_s;
            borrow_r        <= b_out_s;
            cnt_r           <= cnt_r + CW'(1);
        end else begin
            borrow_r <= borrow_r;
        end
    end

    // Result handshake flags: sign and valid settle on the final chunk, valid drops on acceptance.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            q_sign_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (last_s) begin
            q_sign_r    <= b_out_s;
            out_valid_r <= 1'b1;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef Q_OTF_ZERO_DETECT_EN
    logic nz_r;
    logic q_zero_r;

    // Sticky non-zero accumulator per chunk; the final borrow is folded in on the last chunk.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            nz_r     <= 1'b0;
            q_zero_r <= 1'b0;
        end else if (load_s) begin
            nz_r <= 1'b0;
        end else if (step_s) begin
            nz_r <= nz_r | (|diff_s);
            if (last_s) begin
                q_zero_r <= ~(nz_r | (|diff_s) | b_out_s);
            end else begin
                q_zero_r <= q_zero_r;
            end
        end else begin
            nz_r <= nz_r;
        end
    end

    assign q_zero = q_zero_r;
`endif

    assign in_ready  = in_ready_s;
    assign busy      = (state_r == CONV);
    assign q_conv    = result_r;
    assign q_sign    = q_sign_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_q_otf_convert.sv
// Self-checking bench for q_otf_convert: directed and random digit pairs against a
// plain wide-subtraction reference model.
module tb_q_otf_convert;

    localparam int U   = 64;
    localparam int C   = 8;
    localparam int NCH = U / C;

    logic         clk = 1'b0;
    logic         asyn_reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [U-1:0] q_plus;
    logic [U-1:0] q_minus;
    logic         out_valid;
    logic         out_ready;
    logic [U-1:0] q_conv;
    logic         q_sign;
    logic         busy;
`ifdef Q_OTF_ZERO_DETECT_EN
    logic         q_zero;
`endif

    int checks = 0;
    int errors = 0;

    q_otf_convert #(
        .UNROLLING (U),
        .CHUNK     (C)
    ) dut (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .q_plus       (q_plus),
        .q_minus      (q_minus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .q_conv       (q_conv),
        .q_sign       (q_sign),
        .busy         (busy)
`ifdef Q_OTF_ZERO_DETECT_EN
        ,
        .q_zero       (q_zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {sign, value} of the unbounded difference p - m.
    function automatic logic [U:0] ref_sub(input logic [U-1:0] p, input logic [U-1:0] m);
        logic [U:0] r;
        r = {1'b0, p} - {1'b0, m};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait for acceptance, then count clocks until out_valid.
    task automatic start_and_wait(input logic [U-1:0] p, input logic [U-1:0] m, output int lat);
        int guard;
        q_plus   = p;
        q_minus  = m;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        asyn_reset_n = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        q_plus       = '0;
        q_minus      = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (q_conv !== 64'd0) begin errors++; $display("FAIL reset_q_conv got=%h exp=0", q_conv); end
        checks++; if (q_sign !== 1'b0) begin errors++; $display("FAIL reset_q_sign got=%b exp=0", q_sign); end
`ifdef Q_OTF_ZERO_DETECT_EN
        checks++; if (q_zero !== 1'b0) begin errors++; $display("FAIL reset_q_zero got=%b exp=0", q_zero); end
`endif
        @(negedge clk);
        asyn_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        start_and_wait(64'h5, 64'h3, lat);
        checks++; if (lat != NCH) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NCH); end
        checks++; if (q_conv !== 64'h2) begin errors++; $display("FAIL basic_q_conv got=%h exp=2", q_conv); end
        checks++; if (q_sign !== 1'b0) begin errors++; $display("FAIL basic_q_sign got=%b exp=0", q_sign); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_negative();
        int lat;
        out_ready = 1'b1;
        start_and_wait(64'h0, 64'h1, lat);
        checks++; if (q_conv !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL neg_q_conv got=%h exp=ffffffffffffffff", q_conv); end
        checks++; if (q_sign !== 1'b1) begin errors++; $display("FAIL neg_q_sign got=%b exp=1", q_sign); end
`ifdef Q_OTF_ZERO_DETECT_EN
        checks++; if (q_zero !== 1'b0) begin errors++; $display("FAIL neg_q_zero got=%b exp=0", q_zero); end
`endif
        tick();
    endtask

    task automatic test_borrow_chain();
        int lat;
        out_ready = 1'b1;
        start_and_wait(64'h0, 64'h100, lat);
        checks++; if (q_conv !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++; $display("FAIL chain_q_conv got=%h exp=ffffffffffffff00", q_conv); end
        checks++; if (q_sign !== 1'b1) begin errors++; $display("FAIL chain_q_sign got=%b exp=1", q_sign); end
        tick();
    endtask

    task automatic test_random();
        int           lat;
        logic [U-1:0] p;
        logic [U-1:0] m;
        logic [U:0]   e;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = {$urandom, $urandom};
            m = (i == 5) ? p : {$urandom, $urandom};
            e = ref_sub(p, m);
            start_and_wait(p, m, lat);
            checks++; if (q_conv !== e[U-1:0]) begin errors++; $display("FAIL rand_q_conv[%0d] got=%h exp=%h", i, q_conv, e[U-1:0]); end
            checks++; if (q_sign !== e[U]) begin errors++; $display("FAIL rand_q_sign[%0d] got=%b exp=%b", i, q_sign, e[U]); end
`ifdef Q_OTF_ZERO_DETECT_EN
            checks++; if (q_zero !== (e == 65'd0)) begin errors++; $display("FAIL rand_q_zero[%0d] got=%b exp=%b", i, q_zero, (e == 65'd0)); end
`endif
            tick();
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [U-1:0] p1, m1, p2, m2;
        logic [U:0]   e1, e2;
        p1 = {$urandom, $urandom};
        m1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        e1 = ref_sub(p1, m1);
        e2 = ref_sub(p2, m2);
        out_ready = 1'b0;
        start_and_wait(p1, m1, lat);
        q_plus   = p2;
        q_minus  = m2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || q_conv !== e1[U-1:0] || q_sign !== e1[U] || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%b conv=%h sign=%b ready=%b busy=%b exp valid=1 conv=%h sign=%b ready=0 busy=0",
                         i, out_valid, q_conv, q_sign, in_ready, busy, e1[U-1:0], e1[U]);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_chain_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_chain_accept got busy=%b valid=%b exp busy=1 valid=0", busy, out_valid); end
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        checks++; if (lat != NCH) begin errors++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, NCH); end
        checks++; if (q_conv !== e2[U-1:0] || q_sign !== e2[U]) begin errors++; $display("FAIL bp_second_result got=%b_%h exp=%b_%h", q_sign, q_conv, e2[U], e2[U-1:0]); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        q_plus    = 64'hFFFF_FFFF_FFFF_FFFF;
        q_minus   = 64'h1234_5678_0000_0001;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
        asyn_reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || q_conv !== 64'd0 || q_sign !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got valid=%b ready=%b busy=%b conv=%h sign=%b exp 0 1 0 0 0",
                     out_valid, in_ready, busy, q_conv, q_sign);
        end
        @(negedge clk);
        asyn_reset_n = 1'b1;
        tick();
        start_and_wait(64'hA, 64'hA, lat);
        checks++; if (lat != NCH) begin errors++; $display("FAIL rst_after_latency got=%0d exp=%0d", lat, NCH); end
        checks++; if (q_conv !== 64'd0 || q_sign !== 1'b0) begin errors++; $display("FAIL rst_after_equal got=%b_%h exp=0_0", q_sign, q_conv); end
`ifdef Q_OTF_ZERO_DETECT_EN
        checks++; if (q_zero !== 1'b1) begin errors++; $display("FAIL rst_after_q_zero got=%b exp=1", q_zero); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        logic [U-1:0] ps [4];
        logic [U-1:0] ms [4];
        logic [U:0]   exp_q [$];
        int           idx, cyc, got, last_cyc;
        logic         acc;
        for (int i = 0; i < 4; i++) begin
            ps[i] = {$urandom, $urandom};
            ms[i] = {$urandom, $urandom};
            exp_q.push_back(ref_sub(ps[i], ms[i]));
        end
        out_ready = 1'b1;
        idx       = 0;
        q_plus    = ps[0];
        q_minus   = ms[0];
        in_valid  = 1'b1;
        cyc       = 0;
        got       = 0;
        last_cyc  = 0;
        while (got < 4 && cyc < 200) begin
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    q_plus  = ps[idx];
                    q_minus = ms[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                checks++;
                if (q_conv !== exp_q[got][U-1:0] || q_sign !== exp_q[got][U]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got=%b_%h exp=%b_%h", got, q_sign, q_conv, exp_q[got][U], exp_q[got][U-1:0]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last_cyc != NCH + 1) begin
                        errors++;
                        $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", got, cyc - last_cyc, NCH + 1);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", got); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_borrow_chain();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
